// File: rtl/sc_mio_responder.sv
// Memory/IO responder for the SCPU_v1 bus: instruction ROM, data RAM, LED register and
// free-running cycle counter, answering each request with a one-cycle MIO_ready pulse.
module sc_mio_responder #(
    parameter int unsigned ROM_DEPTH   = 256,
    parameter int unsigned RAM_DEPTH   = 256,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_req,
    input  logic        mem_w,
    input  logic [31:0] PC_out,
    input  logic [31:0] Addr_out,
    input  logic [31:0] Data_out,
    output logic        MIO_ready,
    output logic [31:0] inst_in,
    output logic [31:0] Data_in,
    output logic [15:0] led_out,
    output logic        bus_err,
    input  logic        prog_we,
    input  logic [31:0] prog_addr,
    input  logic [31:0] prog_data
);
    localparam int unsigned RomAw    = $clog2(ROM_DEPTH);
    localparam int unsigned RamAw    = $clog2(RAM_DEPTH);
    localparam logic [29:0] LedWord  = 30'h3C00_0000;
    localparam logic [29:0] CntWord  = 30'h3C00_0001;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      r_state, w_state_next;
    logic [3:0]  r_wait_cnt, w_wait_cnt_next;
    logic [29:0] r_pc_word, r_addr_word;
    logic [31:0] r_wdata;
    logic        r_we;
    logic [31:0] r_cycle;
    logic [31:0] r_inst_hold, r_data_hold;
    logic [15:0] r_led;
    logic        r_bus_err;
    logic [31:0] r_rom [ROM_DEPTH];
    logic [31:0] r_ram [RAM_DEPTH];

    logic        w_accept, w_resp;
    logic        w_rom_hit, w_ram_hit, w_led_hit, w_cnt_hit, w_unmapped, w_prog_hit;
    logic [31:0] w_inst, w_rdata;
    logic        w_unused_lsbs;

    assign w_unused_lsbs = ^{PC_out[1:0], Addr_out[1:0], prog_addr[1:0]};

    assign w_accept   = (r_state == StIdle) && mem_req && !prog_we;
    assign w_resp     = (r_state == StResp);
    assign w_rom_hit  = (r_pc_word >> RomAw) == '0;
    assign w_ram_hit  = (r_addr_word >> RamAw) == '0;
    assign w_led_hit  = (r_addr_word == LedWord);
    assign w_cnt_hit  = (r_addr_word == CntWord);
    assign w_unmapped = !(w_ram_hit || w_led_hit || w_cnt_hit);
    assign w_prog_hit = (prog_addr[31:2] >> RomAw) == '0;

    // Reads are combinational from the latched addresses so RESP sees pre-write contents.
    always_comb begin
        w_inst  = '0;
        w_rdata = '0;
        if (w_rom_hit) w_inst = r_rom[r_pc_word[RomAw-1:0]];
        if (w_ram_hit)      w_rdata = r_ram[r_addr_word[RamAw-1:0]];
        else if (w_led_hit) w_rdata = {16'b0, r_led};
        else if (w_cnt_hit) w_rdata = r_cycle;
    end

    always_comb begin
        w_state_next    = r_state;
        w_wait_cnt_next = r_wait_cnt;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_wait_cnt_next = 4'(WAIT_CYCLES);
                    w_state_next    = (WAIT_CYCLES > 0) ? StWait : StResp;
                end
            end
            StWait: begin
                w_wait_cnt_next = r_wait_cnt - 4'd1;
                if (r_wait_cnt <= 4'd1) w_state_next = StResp;
            end
            StResp:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= StIdle;
            r_wait_cnt  <= '0;
            r_pc_word   <= '0;
            r_addr_word <= '0;
            r_wdata     <= '0;
            r_we        <= 1'b0;
            r_cycle     <= '0;
            r_inst_hold <= '0;
            r_data_hold <= '0;
            r_led       <= '0;
            r_bus_err   <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_cnt_next;
            r_cycle    <= r_cycle + 32'd1;
            if (w_accept) begin
                r_pc_word   <= PC_out[31:2];
                r_addr_word <= Addr_out[31:2];
                r_wdata     <= Data_out;
                r_we        <= mem_w;
            end
            if (w_resp) begin
                r_inst_hold <= w_inst;
                r_data_hold <= w_rdata;
                if (w_unmapped) r_bus_err <= 1'b1;
                if (r_we && w_led_hit) r_led <= r_wdata[15:0];
            end
        end
    end

    // Storage is not cleared by reset; an in-flight write is dropped when reset hits RESP.
    always_ff @(posedge clk) begin
        if (prog_we && w_prog_hit) r_rom[prog_addr[RomAw+1:2]] <= prog_data;
        if (reset && w_resp && r_we && w_ram_hit) r_ram[r_addr_word[RamAw-1:0]] <= r_wdata;
    end

    assign MIO_ready = w_resp;
    assign inst_in   = w_resp ? w_inst : r_inst_hold;
    assign Data_in   = w_resp ? w_rdata : r_data_hold;
    assign led_out   = r_led;
    assign bus_err   = r_bus_err;

endmodule

// File: tb/tb_sc_mio_responder.sv
// Directed bench for sc_mio_responder: one instance with WAIT_CYCLES=1 for the main
// function and one with WAIT_CYCLES=3 for latency and mid-transaction reset.
module tb_sc_mio_responder;
    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req, mem_req_w3, mem_w, prog_we;
    logic [31:0] PC_out, Addr_out, Data_out, prog_addr, prog_data;
    logic        MIO_ready, bus_err, rdy_w3, err_w3;
    logic [31:0] inst_in, Data_in, inst_w3, data_w3;
    logic [15:0] led_out, led_w3;

    int n_vec = 0;
    int n_err = 0;
    int lat;
    int pulses;
    logic [31:0] c1, c2, v;

    always #5 clk = ~clk;

    sc_mio_responder #(.ROM_DEPTH(256), .RAM_DEPTH(256), .WAIT_CYCLES(1)) u_dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_w(mem_w),
        .PC_out(PC_out), .Addr_out(Addr_out), .Data_out(Data_out),
        .MIO_ready(MIO_ready), .inst_in(inst_in), .Data_in(Data_in),
        .led_out(led_out), .bus_err(bus_err),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data)
    );

    sc_mio_responder #(.ROM_DEPTH(256), .RAM_DEPTH(256), .WAIT_CYCLES(3)) u_dut_w3 (
        .clk(clk), .reset(reset), .mem_req(mem_req_w3), .mem_w(mem_w),
        .PC_out(PC_out), .Addr_out(Addr_out), .Data_out(Data_out),
        .MIO_ready(rdy_w3), .inst_in(inst_w3), .Data_in(data_w3),
        .led_out(led_w3), .bus_err(err_w3),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic prog(input logic [31:0] addr, input logic [31:0] data);
        prog_we   = 1'b1;
        prog_addr = addr;
        prog_data = data;
        tick();
        prog_we   = 1'b0;
    endtask

    task automatic set_req(input bit sel3, input logic [31:0] pc, input logic [31:0] addr,
                           input logic [31:0] wd, input logic we);
        PC_out   = pc;
        Addr_out = addr;
        Data_out = wd;
        mem_w    = we;
        if (sel3) mem_req_w3 = 1'b1;
        else      mem_req    = 1'b1;
    endtask

    // Counts edges until the selected MIO_ready is seen; 20 means it never came.
    task automatic wait_ready(input bit sel3, output int n);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n++;
            if ((sel3 ? rdy_w3 : MIO_ready) === 1'b1) break;
        end
        if ((sel3 ? rdy_w3 : MIO_ready) !== 1'b1) n = 20;
        mem_req    = 1'b0;
        mem_req_w3 = 1'b0;
    endtask

    task automatic xact(input bit sel3, input logic [31:0] pc, input logic [31:0] addr,
                        input logic [31:0] wd, input logic we, output int n);
        set_req(sel3, pc, addr, wd, we);
        wait_ready(sel3, n);
    endtask

    initial begin
        reset = 1'b0; mem_req = 1'b0; mem_req_w3 = 1'b0; mem_w = 1'b0; prog_we = 1'b0;
        PC_out = '0; Addr_out = '0; Data_out = '0; prog_addr = '0; prog_data = '0;
        tick();
        // ROM preload is allowed while reset is held
        prog(32'h0, 32'h0232_9820);
        prog(32'h4, 32'h8DF0_0004);
        prog(32'hC, 32'h3333_3333);
        set_req(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        tick();
        tick();
        check_eq("rst_ready", {31'b0, MIO_ready}, 32'h0);
        check_eq("rst_led", {16'b0, led_out}, 32'h0);
        check_eq("rst_err", {31'b0, bus_err}, 32'h0);
        check_eq("rst_inst", inst_in, 32'h0);

        reset = 1'b1;
        wait_ready(1'b0, lat);
        check_eq("first_lat", lat, 32'd2);
        check_eq("fetch0", inst_in, 32'h0232_9820);
        tick();
        check_eq("pulse_low", {31'b0, MIO_ready}, 32'h0);
        check_eq("inst_hold", inst_in, 32'h0232_9820);

        xact(1'b0, 32'h4, 32'h0, 32'h0, 1'b0, lat);
        check_eq("fetch1", inst_in, 32'h8DF0_0004);
        tick();

        xact(1'b0, 32'h0, 32'h0, 32'h1111_1111, 1'b1, lat);
        tick();
        xact(1'b0, 32'h0, 32'h4, 32'h0, 1'b1, lat);
        tick();
        xact(1'b0, 32'h0, 32'h4, 32'hCDCD_CDCD, 1'b1, lat);
        check_eq("wr_old_data", Data_in, 32'h0);
        tick();
        xact(1'b0, 32'h0, 32'h4, 32'h0, 1'b0, lat);
        check_eq("ram_rd", Data_in, 32'hCDCD_CDCD);
        tick();

        xact(1'b0, 32'h0, 32'hF000_0000, 32'h1234_ABCD, 1'b1, lat);
        tick();
        check_eq("led_out", {16'b0, led_out}, 32'h0000_ABCD);
        xact(1'b0, 32'h0, 32'hF000_0000, 32'h0, 1'b0, lat);
        check_eq("led_rd", Data_in, 32'h0000_ABCD);
        tick();

        xact(1'b0, 32'h0, 32'hF000_0004, 32'h5A5A_5A5A, 1'b1, lat);
        tick();
        check_eq("cnt_wr_noerr", {31'b0, bus_err}, 32'h0);

        xact(1'b0, 32'h0, 32'h8000_0000, 32'h5555_5555, 1'b1, lat);
        tick();
        check_eq("err_set", {31'b0, bus_err}, 32'h1);
        xact(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, lat);
        check_eq("ram0_kept", Data_in, 32'h1111_1111);
        tick();
        xact(1'b0, 32'h0, 32'h8000_0000, 32'h0, 1'b0, lat);
        check_eq("unmap_rd", Data_in, 32'h0);
        tick();
        check_eq("err_sticky", {31'b0, bus_err}, 32'h1);

        xact(1'b0, 32'd1024, 32'h0, 32'h0, 1'b0, lat);
        check_eq("fetch_oor", inst_in, 32'h0);
        tick();

        xact(1'b0, 32'h0, 32'hF000_0004, 32'h0, 1'b0, lat);
        c1 = Data_in;
        repeat (5) tick();
        xact(1'b0, 32'h0, 32'hF000_0004, 32'h0, 1'b0, lat);
        c2 = Data_in;
        check_eq("cnt_delta", c2 - c1, 32'd7);
        tick();

        // prog_we in IDLE delays acceptance by one cycle; the new ROM word is fetched
        set_req(1'b0, 32'h8, 32'h0, 32'h0, 1'b0);
        prog_we = 1'b1; prog_addr = 32'h8; prog_data = 32'hAAAA_0001;
        tick();
        prog_we = 1'b0;
        wait_ready(1'b0, lat);
        check_eq("prog_block_lat", lat, 32'd2);
        check_eq("prog_fetch", inst_in, 32'hAAAA_0001);
        tick();

        // ROM write during WAIT is seen in RESP
        set_req(1'b0, 32'hC, 32'h0, 32'h0, 1'b0);
        tick();
        prog_we = 1'b1; prog_addr = 32'hC; prog_data = 32'hBEEF_0003;
        wait_ready(1'b0, lat);
        prog_we = 1'b0;
        check_eq("prog_in_wait", inst_in, 32'hBEEF_0003);
        tick();

        xact(1'b1, 32'h0, 32'h8, 32'h2222_2222, 1'b1, lat);
        check_eq("w3_lat", lat, 32'd4);
        tick();

        set_req(1'b1, 32'h0, 32'h8, 32'hDEAD_BEEF, 1'b1);
        tick();
        tick();
        reset      = 1'b0;
        mem_req_w3 = 1'b0;
        pulses     = 0;
        tick();
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (rdy_w3 === 1'b1) pulses++;
            tick();
        end
        check_eq("midwait_pulses", pulses, 32'd0);
        check_eq("rst_clr_err", {31'b0, bus_err}, 32'h0);
        check_eq("rst_clr_led", {16'b0, led_out}, 32'h0);
        xact(1'b1, 32'h0, 32'h8, 32'h0, 1'b0, lat);
        v = data_w3;
        check_eq("midwait_lat", lat, 32'd4);
        check_eq("midwait_ram", v, 32'h2222_2222);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
